alu_issue: RTL and testbench
============================

# alu_issue

Decode-and-issue stage that drives the combinational ALU: accepts an RV32 instruction word plus register-file operand values over a valid/ready handshake, decodes opcode/funct3/funct7 into the 6-bit ALU operation code, selects operands (register, immediate or zero), and presents them to the ALU one cycle later. Sits between register read and execute/writeback. A two-entry skid buffer makes the upstream `o_ready` a pure register output.

## Interface
- No parameters; data width fixed at 32, ALU op width fixed at 6.
- `i_clk` in 1: single clock, rising edge.
- `i_rst` in 1: reset, asynchronous and active-high.
- `i_valid` in 1: upstream instruction valid.
- `o_ready` out 1: stage can accept; registered.
- `i_instr` in 32: RV32 instruction word.
- `i_rs1_val` in 32: register rs1 value.
- `i_rs2_val` in 32: register rs2 value.
- `o_valid` out 1: issued operation valid.
- `i_ready` in 1: ALU/writeback side accepts.
- `o_alu_op` out 6: ALU operation code.
- `o_a` out 32: ALU operand A.
- `o_b` out 32: ALU operand B.
- `o_rd` out 5: destination register (`instr[11:7]`).
- `o_wen` out 1: writeback enable; 1 iff legal and rd≠0.
- `o_illegal` out 1: instruction not supported by this stage.

## Operation
- Op codes: NOP 000000, ADD 001001, SUB 001010, MUL 001011, DIV 001100, AND 010001, OR 010011, XOR 010100, SLT 011001, SLL 011011, SRL 011100, SRA 011101.
- OP (opcode 0110011), A=rs1, B=rs2:
  - funct7 0000000: f3 000 ADD, 001 SLL, 010 SLT, 100 XOR, 101 SRL, 110 OR, 111 AND.
  - funct7 0100000: f3 000 SUB, 101 SRA.
  - funct7 0000001: f3 000 MUL, 100 DIV.
  - All other combinations illegal, including SLTU (f3 011).
- OP-IMM (0010011), A=rs1:
  - Non-shifts: B = sign-extended `instr[31:20]`; f3 000 ADD, 010 SLT, 100 XOR, 110 OR, 111 AND. SLTIU (011) illegal.
  - Shifts: B = {27'b0, `instr[24:20]`}. SLLI needs f3 001 and funct7 0000000. SRLI needs f3 101 and funct7 0000000. SRAI needs f3 101 and funct7 0100000. Any other funct7 is illegal.
- LUI (0110111): op ADD, A=0, B={`instr[31:12]`,12'b0}.
- Any other opcode, or instr[1:0]≠11: illegal.
- Illegal entries still pass through the handshake in order with o_alu_op=NOP, o_a=o_b=0, o_wen=0, o_illegal=1; o_rd is still forwarded.
- Decode is combinational on the input side; the decoded bundle is stored, never raw instruction fields.
- Storage: output register (main) plus one skid register. States by occupancy: EMPTY (main invalid), ONE (main valid, skid empty), FULL (both valid).
  - EMPTY + accept → ONE.
  - ONE + accept, no drain → FULL (incoming bundle goes to skid).
  - ONE + drain, no accept → EMPTY.
  - ONE + accept and drain → ONE (incoming bundle goes to main).
  - FULL + drain → ONE (skid moves to main).
- Accept = i_valid & o_ready. Drain = o_valid & i_ready. o_ready = !skid_valid, registered. o_valid = main_valid.

## Timing
- Reset (async assert, applied immediately): o_valid=0, o_ready=1, o_alu_op=000000, o_a=o_b=0, o_rd=0, o_wen=0, o_illegal=0, skid empty. Reset mid-transfer discards both entries.
- Latency: an instruction accepted on edge N is presented on o_valid after edge N when main was empty or draining on that edge.
- Throughput: one op per cycle while i_ready=1.
- Output stability: while o_valid=1 and i_ready=0, all output fields hold constant.
- o_ready drops the cycle after the skid fills. While i_ready is low it stays low. It returns to 1 the cycle after the first drain from FULL.
- FULL: no accept is possible because o_ready=0. Upstream data presented then is ignored.
- Order is strictly FIFO: the skid entry always issues after the main entry.
- Simultaneous accept and drain in ONE: main reloads with the new bundle and there is no bubble.
- Downstream may drop i_ready in any cycle. Upstream must hold i_valid and its data until accepted.

## Test plan
- Reset, then ADD x3,x1,x2 with rs1=5, rs2=7, i_ready=1: next cycle o_alu_op=001001, o_a=5, o_b=7, o_rd=3, o_wen=1.
- SRAI x4,x1,3 (instr 0x4030D213), rs1=0x80000000: o_alu_op=011101, o_b=3. SLTIU or SLLI with funct7 0100000: o_illegal=1, o_alu_op=000000, o_wen=0.
- ADDI x1,x0,-1 (0xFFF00093): o_b=0xFFFFFFFF. LUI x5,0x12345 (0x123452B7): o_a=0, o_b=0x12345000, op ADD.
- Hold i_ready=0 and issue 3 back-to-back instrs: o_ready=0 after the second accept and the third is held upstream. Release i_ready: issue order is 1,2,3 with no loss or duplication.
- Random i_valid/i_ready at 50% over 10k instrs: scoreboard matches decode model and order; outputs are stable while stalled.
- Assert i_rst while FULL: o_valid=0 and o_ready=1 immediately. The first post-reset instruction issues correctly.

Source files
------------

// File: rtl/alu_issue.sv
// alu_issue: RV32 decode-and-issue stage feeding the ALU through a two-entry skid buffer.
// Revision: 1.0
`default_nettype none

module alu_issue (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [31:0] i_instr,
  input  logic [31:0] i_rs1_val,
  input  logic [31:0] i_rs2_val,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [5:0]  o_alu_op,
  output logic [31:0] o_a,
  output logic [31:0] o_b,
  output logic [4:0]  o_rd,
  output logic        o_wen,
  output logic        o_illegal
);

  localparam logic [5:0] OP_NOP = 6'b000000;
  localparam logic [5:0] OP_ADD = 6'b001001;
  localparam logic [5:0] OP_SUB = 6'b001010;
  localparam logic [5:0] OP_MUL = 6'b001011;
  localparam logic [5:0] OP_DIV = 6'b001100;
  localparam logic [5:0] OP_AND = 6'b010001;
  localparam logic [5:0] OP_OR  = 6'b010011;
  localparam logic [5:0] OP_XOR = 6'b010100;
  localparam logic [5:0] OP_SLT = 6'b011001;
  localparam logic [5:0] OP_SLL = 6'b011011;
  localparam logic [5:0] OP_SRL = 6'b011100;
  localparam logic [5:0] OP_SRA = 6'b011101;

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MULD = 7'b0000001;

  typedef struct packed {
    logic [5:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic        wen;
    logic        illegal;
  } bundle_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rd;
  logic [4:0]  shamt;
  logic        legal;
  logic [5:0]  op_d;
  logic [31:0] a_d;
  logic [31:0] b_d;
  bundle_t     dec;

  assign opcode = i_instr[6:0];
  assign rd     = i_instr[11:7];
  assign funct3 = i_instr[14:12];
  assign shamt  = i_instr[24:20];
  assign funct7 = i_instr[31:25];

  // opcode includes instr[1:0], so non-32-bit encodings fall to the default arm
  always_comb begin
    legal = 1'b0;
    op_d  = OP_NOP;
    a_d   = '0;
    b_d   = '0;
    case (opcode)
      OPC_OP: begin
        legal = 1'b1;
        a_d   = i_rs1_val;
        b_d   = i_rs2_val;
        case ({funct7, funct3})
          {F7_BASE, 3'b000}: op_d = OP_ADD;
          {F7_BASE, 3'b001}: op_d = OP_SLL;
          {F7_BASE, 3'b010}: op_d = OP_SLT;
          {F7_BASE, 3'b100}: op_d = OP_XOR;
          {F7_BASE, 3'b101}: op_d = OP_SRL;
          {F7_BASE, 3'b110}: op_d = OP_OR;
          {F7_BASE, 3'b111}: op_d = OP_AND;
          {F7_ALT,  3'b000}: op_d = OP_SUB;
          {F7_ALT,  3'b101}: op_d = OP_SRA;
          {F7_MULD, 3'b000}: op_d = OP_MUL;
          {F7_MULD, 3'b100}: op_d = OP_DIV;
          default:           legal = 1'b0;
        endcase
      end
      OPC_OPIMM: begin
        legal = 1'b1;
        a_d   = i_rs1_val;
        b_d   = {{20{i_instr[31]}}, i_instr[31:20]};
        case (funct3)
          3'b000: op_d = OP_ADD;
          3'b010: op_d = OP_SLT;
          3'b100: op_d = OP_XOR;
          3'b110: op_d = OP_OR;
          3'b111: op_d = OP_AND;
          3'b001: begin
            b_d   = {27'b0, shamt};
            op_d  = OP_SLL;
            legal = (funct7 == F7_BASE);
          end
          3'b101: begin
            b_d = {27'b0, shamt};
            if (funct7 == F7_BASE)     op_d = OP_SRL;
            else if (funct7 == F7_ALT) op_d = OP_SRA;
            else                       legal = 1'b0;
          end
          default: legal = 1'b0;
        endcase
      end
      OPC_LUI: begin
        legal = 1'b1;
        op_d  = OP_ADD;
        b_d   = {i_instr[31:12], 12'b0};
      end
      default: legal = 1'b0;
    endcase
  end

  assign dec = legal ?
      bundle_t'{op: op_d, a: a_d, b: b_d, rd: rd, wen: (rd != 5'd0), illegal: 1'b0} :
      bundle_t'{op: OP_NOP, a: 32'd0, b: 32'd0, rd: rd, wen: 1'b0, illegal: 1'b1};

  state_t  state_q;
  state_t  state_d;
  bundle_t main_q;
  bundle_t skid_q;
  logic    ready_q;
  logic    accept;
  logic    drain;
  logic    load_main;
  logic    load_skid;
  logic    move_skid;

  assign accept = i_valid & ready_q;
  assign drain  = (state_q != EMPTY) & i_ready;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= EMPTY;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    load_main = 1'b0;
    load_skid = 1'b0;
    move_skid = 1'b0;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d   = ONE;
          load_main = 1'b1;
        end
      end
      ONE: begin
        if (accept && drain) begin
          load_main = 1'b1;
        end else if (accept) begin
          state_d   = FULL;
          load_skid = 1'b1;
        end else if (drain) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (drain) begin
          state_d   = ONE;
          move_skid = 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // ready is registered from the next occupancy so upstream sees no combinational path
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      main_q  <= '0;
      skid_q  <= '0;
      ready_q <= 1'b1;
    end else begin
      if (load_main)      main_q <= dec;
      else if (move_skid) main_q <= skid_q;
      if (load_skid)      skid_q <= dec;
      ready_q <= (state_d != FULL);
    end
  end

  assign o_ready   = ready_q;
  assign o_valid   = (state_q != EMPTY);
  assign o_alu_op  = main_q.op;
  assign o_a       = main_q.a;
  assign o_b       = main_q.b;
  assign o_rd      = main_q.rd;
  assign o_wen     = main_q.wen;
  assign o_illegal = main_q.illegal;

endmodule

`default_nettype wire

// File: tb/tb_alu_issue.sv
// tb_alu_issue: scoreboard bench for alu_issue with a table-driven decode model.
// Revision: 1.0
`default_nettype none

module tb_alu_issue;

  typedef struct packed {
    logic [5:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic        wen;
    logic        illegal;
  } bundle_t;

  localparam logic [5:0] NOP = 6'b000000, ADD = 6'b001001, SUB = 6'b001010,
                         MUL = 6'b001011, DIV = 6'b001100, AND_ = 6'b010001,
                         OR_ = 6'b010011, XOR_ = 6'b010100, SLT = 6'b011001,
                         SLL = 6'b011011, SRL = 6'b011100, SRA = 6'b011101;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_valid;
  logic        o_ready;
  logic [31:0] i_instr;
  logic [31:0] i_rs1_val;
  logic [31:0] i_rs2_val;
  logic        o_valid;
  logic        i_ready;
  logic [5:0]  o_alu_op;
  logic [31:0] o_a;
  logic [31:0] o_b;
  logic [4:0]  o_rd;
  logic        o_wen;
  logic        o_illegal;

  alu_issue dut (
    .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_instr(i_instr), .i_rs1_val(i_rs1_val), .i_rs2_val(i_rs2_val),
    .o_valid(o_valid), .i_ready(i_ready), .o_alu_op(o_alu_op), .o_a(o_a),
    .o_b(o_b), .o_rd(o_rd), .o_wen(o_wen), .o_illegal(o_illegal)
  );

  always #5 clk = ~clk;

  int      total = 0;
  int      passed = 0;
  int      n_acc = 0;
  int      n_pop = 0;
  int      ready_mode = 0;
  bundle_t sb[$];
  int      op_tab[int];
  int      imm_tab[int];

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  function automatic bundle_t mk(logic [5:0] op, logic [31:0] a, logic [31:0] b,
                                 logic [4:0] rd, logic wen, logic ill);
    mk = '{op: op, a: a, b: b, rd: rd, wen: wen, illegal: ill};
  endfunction

  // Reference decode: legal encodings are looked up in tables keyed by fields
  function automatic bundle_t ref_decode(logic [31:0] ins, logic [31:0] r1, logic [31:0] r2);
    bundle_t r;
    int      key;
    int      f3;
    int      f7;
    r = mk(NOP, 0, 0, ins[11:7], 1'b0, 1'b1);
    f3 = int'(ins[14:12]);
    f7 = int'(ins[31:25]);
    key = f7 * 8 + f3;
    if (ins[6:0] == 7'h33 && op_tab.exists(key)) begin
      r.op = 6'(op_tab[key]); r.a = r1; r.b = r2; r.illegal = 1'b0;
    end else if (ins[6:0] == 7'h13) begin
      if (imm_tab.exists(f3)) begin
        r.op = 6'(imm_tab[f3]); r.a = r1;
        r.b = 32'(int'($signed(ins[31:20]))); r.illegal = 1'b0;
      end else if ((f3 == 1 && f7 == 0) || (f3 == 5 && (f7 == 0 || f7 == 32))) begin
        r.op = (f3 == 1) ? SLL : (f7 == 0 ? SRL : SRA);
        r.a = r1; r.b = 32'(ins[24:20]); r.illegal = 1'b0;
      end
    end else if (ins[6:0] == 7'h37) begin
      r.op = ADD; r.a = 0; r.b = ins & 32'hFFFF_F000; r.illegal = 1'b0;
    end
    r.wen = !r.illegal && (r.rd != 0);
    return r;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    logic [31:0] v;
    logic [6:0]  f7;
    logic [11:0] imm;
    int          k;
    int          sel;
    k   = $urandom_range(0, 9);
    sel = $urandom_range(0, 3);
    w   = $urandom;
    v   = $urandom;
    f7  = (sel == 0) ? 7'h00 : (sel == 1) ? 7'h20 : (sel == 2) ? 7'h01 : w[31:25];
    imm = w[31:20];
    if (sel < 2) imm[11:5] = f7;
    case (k)
      0, 1, 2: return {f7, w[24:12], w[11:7], 7'h33};
      3, 4, 5: return {imm, w[19:7], 7'h13};
      6:       return {w[31:7], 7'h37};
      7:       return w;
      8:       return {f7, w[24:7], 5'b01100, 2'(v % 3)};
      default: return {w[31:7], v[6:0]};
    endcase
  endfunction

  // Stimulus is applied 1 time unit after a rising edge; returns at the same phase
  task automatic send(input logic [31:0] ins, input logic [31:0] r1, input logic [31:0] r2);
    logic rdy;
    i_valid = 1'b1; i_instr = ins; i_rs1_val = r1; i_rs2_val = r2;
    for (int t = 0; t < 2000; t++) begin
      @(negedge clk); rdy = o_ready;
      @(posedge clk);
      if (rdy) begin
        sb.push_back(ref_decode(ins, r1, r2));
        n_acc++;
        #1; i_valid = 1'b0;
        return;
      end
    end
    $display("FAIL accept_timeout: instr %h never accepted", ins);
    $fatal(1, "accept timeout");
  endtask

  task automatic wait_drain(input string name);
    logic done;
    done = 1'b0;
    for (int t = 0; t < 5000 && !done; t++) begin
      @(negedge clk);
      if (sb.size() == 0 && !o_valid) done = 1'b1;
    end
    check(name, 80'(done), 80'd1);
    @(posedge clk); #1;
  endtask

  task automatic directed(input string name, input logic [31:0] ins, input logic [31:0] r1,
                          input logic [31:0] r2, input bundle_t exp);
    wait_drain({name, "_drain"});
    send(ins, r1, r2);
    check(name, {o_valid, o_alu_op, o_a, o_b, o_rd, o_wen, o_illegal}, {1'b1, exp});
  endtask

  always @(posedge clk) begin
    #2;
    case (ready_mode)
      0:       i_ready = 1'b1;
      1:       i_ready = 1'b0;
      default: i_ready = $urandom_range(0, 1) == 1;
    endcase
  end

  // Monitor: pops on every drain, and checks outputs hold through stalls
  logic    prev_stall = 1'b0;
  bundle_t prev_b;
  always @(negedge clk) begin
    bundle_t act;
    bundle_t exp;
    act = {o_alu_op, o_a, o_b, o_rd, o_wen, o_illegal};
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) check("stall_hold", {o_valid, act}, {1'b1, prev_b});
      prev_stall = o_valid && !i_ready;
      prev_b = act;
      if (o_valid && i_ready) begin
        n_pop++;
        if (sb.size() == 0) begin
          check("unexpected_issue", 80'(act), 80'(~act));
        end else begin
          exp = sb.pop_front();
          check("scoreboard", 80'(act), 80'(exp));
        end
      end
    end
  end

  initial begin
    logic burst_done;
    int   base;
    op_tab[0*8+0] = ADD;  op_tab[0*8+1] = SLL; op_tab[0*8+2] = SLT;
    op_tab[0*8+4] = XOR_; op_tab[0*8+5] = SRL; op_tab[0*8+6] = OR_;
    op_tab[0*8+7] = AND_; op_tab[32*8+0] = SUB; op_tab[32*8+5] = SRA;
    op_tab[1*8+0] = MUL;  op_tab[1*8+4] = DIV;
    imm_tab[0] = ADD; imm_tab[2] = SLT; imm_tab[4] = XOR_; imm_tab[6] = OR_; imm_tab[7] = AND_;

    rst = 1'b1; i_valid = 1'b0; i_instr = '0; i_rs1_val = '0; i_rs2_val = '0; i_ready = 1'b1;
    #3;
    check("reset_state", {o_valid, o_ready, o_alu_op, o_a, o_b, o_rd, o_wen, o_illegal},
          {2'b01, 77'd0});
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    directed("add", 32'h002081B3, 32'd5, 32'd7, mk(ADD, 5, 7, 3, 1, 0));
    directed("srai", 32'h4030D213, 32'h8000_0000, 32'd9, mk(SRA, 32'h8000_0000, 3, 4, 1, 0));
    directed("sltiu", 32'h00513093, 32'd11, 32'd12, mk(NOP, 0, 0, 1, 0, 1));
    directed("slli_bad_f7", 32'h40311093, 32'd11, 32'd12, mk(NOP, 0, 0, 1, 0, 1));
    directed("addi_neg", 32'hFFF00093, 32'd0, 32'd3, mk(ADD, 0, 32'hFFFF_FFFF, 1, 1, 0));
    directed("lui", 32'h123452B7, 32'hDEAD_BEEF, 32'd3, mk(ADD, 0, 32'h1234_5000, 5, 1, 0));

    // Stalled burst of three: only two fit, the third waits upstream
    wait_drain("burst_pre_drain");
    ready_mode = 1;
    base = n_acc;
    burst_done = 1'b0;
    fork
      begin
        send(32'h002081B3, 32'd1, 32'd2);
        send(32'h40208233, 32'd10, 32'd3);
        send(32'h0220C2B3, 32'd100, 32'd7);
        burst_done = 1'b1;
      end
    join_none
    repeat (6) @(posedge clk);
    #1;
    check("burst_accepts", 80'(n_acc - base), 80'd2);
    check("burst_ready_low", {o_valid, o_ready}, 80'b10);
    ready_mode = 0;
    for (int t = 0; t < 50 && !burst_done; t++) @(posedge clk);
    #1;
    check("burst_done", 80'(burst_done), 80'd1);
    wait_drain("burst_drain");

    // Reset while FULL discards both entries
    ready_mode = 1;
    @(posedge clk); #1;
    send(32'h002081B3, 32'd1, 32'd2);
    send(32'h002081B3, 32'd3, 32'd4);
    check("full_ready_low", {o_valid, o_ready}, 80'b10);
    #1 rst = 1'b1;
    #1 check("reset_full", {o_valid, o_ready}, 80'b01);
    sb.delete();
    n_pop = n_acc;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    ready_mode = 0;
    directed("post_reset_add", 32'h002081B3, 32'd20, 32'd22, mk(ADD, 20, 22, 3, 1, 0));

    ready_mode = 2;
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        i_valid = 1'b0; i_instr = $urandom;
        @(posedge clk); #1;
      end
      send(rand_instr(), $urandom, $urandom);
    end
    ready_mode = 0;
    wait_drain("final_drain");
    check("issue_count", 80'(n_pop), 80'(n_acc));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
